ipsmacge_txwaitsch: RTL and testbench

Transmit-wait scheduler for the GE MAC transmit path. It owns the per-channel wait-request vector that drives the round-robin timeout scanner. It captures each timeout the scanner reports and decides whether to retry or drop the channel. It stalls the scanner through its activity enable until the downstream transmit engine accepts the decision.

---
 rtl/ipsmacge_pkg.sv | 14 +
 rtl/ipsmacge_txwaitsch_stat.sv | 46 ++++
 rtl/ipsmacge_txwaitsch.sv | 132 +++++++++++++
 tb/tb_ipsmacge_txwaitsch.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ipsmacge_pkg.sv
// Shared constants for the GE MAC transmit-wait scheduler: event codes,
// scheduler state encoding and statistics counter width.
package ipsmacge_pkg;

  localparam logic EVT_RETRY = 1'b0;
  localparam logic EVT_DROP  = 1'b1;
  localparam int   STATBIT   = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/ipsmacge_txwaitsch_stat.sv
// Saturating retry/drop event counters for the transmit-wait scheduler.
// Only instantiated when IPSMACGE_TXWAITSCH_STAT_EN is defined.
module ipsmacge_txwaitsch_stat
  import ipsmacge_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               inc_rty_i,
  input  logic               inc_drop_i,
  output logic [STATBIT-1:0] stat_rty_o,
  output logic [STATBIT-1:0] stat_drop_o
);

  logic [STATBIT-1:0] rty_q, rty_d;
  logic [STATBIT-1:0] drop_q, drop_d;

  // Clear beats a coincident increment; counters stick at all-ones.
  always_comb begin
    rty_d  = rty_q;
    drop_d = drop_q;
    if (clr_i) begin
      rty_d  = '0;
      drop_d = '0;
    end else begin
      if (inc_rty_i && (rty_q != '1))
        rty_d = rty_q + 1'b1;
      if (inc_drop_i && (drop_q != '1))
        drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rty_q  <= '0;
      drop_q <= '0;
    end else begin
      rty_q  <= rty_d;
      drop_q <= drop_d;
    end
  end

  assign stat_rty_o  = rty_q;
  assign stat_drop_o = drop_q;

endmodule

// File: rtl/ipsmacge_txwaitsch.sv
// Transmit-wait scheduler: per-channel wait vector, timeout capture with
// retry/drop decision, scanner stall while a decision is pending.
// Optional statistics via IPSMACGE_TXWAITSCH_STAT_EN.
module ipsmacge_txwaitsch
  import ipsmacge_pkg::*;
#(
  parameter int                 NCH    = 256,
  parameter int                 IDBIT  = 8,
  parameter int                 RTYBIT = 2,
  parameter logic [RTYBIT-1:0]  MAXRTY = 2'd3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             req_vld,
  input  logic [IDBIT-1:0] req_id,
  input  logic             ack_vld,
  input  logic [IDBIT-1:0] ack_id,
  output logic [NCH-1:0]   reqwait,
  output logic             upact,
  input  logic             tmo,
  input  logic [IDBIT-1:0] tmoid,
  output logic             evt_vld,
  output logic             evt_drop,
  output logic [IDBIT-1:0] evt_id,
  input  logic             evt_rdy,
  output logic             ack_err
`ifdef IPSMACGE_TXWAITSCH_STAT_EN
  ,
  input  logic               stat_clr,
  output logic [STATBIT-1:0] stat_rty,
  output logic [STATBIT-1:0] stat_drop
`endif
);

  logic [NCH-1:0]    reqwait_q, reqwait_d;
  logic [RTYBIT-1:0] rcnt_q [NCH];
  logic [RTYBIT-1:0] rcnt_d [NCH];
  state_e            state_q, state_d;
  logic              evt_drop_q, evt_drop_d;
  logic [IDBIT-1:0]  evt_id_q, evt_id_d;
  logic              ack_err_q, ack_err_d;

  logic reqIn, ackIn, tmoIn;
  logic ackHit, tmoHit, capRty, capDrop;

  assign reqIn = 32'(req_id) < 32'(NCH);
  assign ackIn = 32'(ack_id) < 32'(NCH);
  assign tmoIn = 32'(tmoid) < 32'(NCH);

  // Scanner only runs while no decision is outstanding.
  assign upact = ~rst & enable & (state_q == ST_IDLE);

  assign ackHit  = ack_vld & ackIn & reqwait_q[ack_id];
  assign tmoHit  = tmo & upact & tmoIn & reqwait_q[tmoid] &
                   ~(ack_vld & (ack_id == tmoid));
  assign capRty  = tmoHit & (rcnt_q[tmoid] < MAXRTY);
  assign capDrop = tmoHit & ~(rcnt_q[tmoid] < MAXRTY);

  // Capture first, then ack, then req, so a request always wins on its id.
  always_comb begin
    reqwait_d  = reqwait_q;
    rcnt_d     = rcnt_q;
    state_d    = state_q;
    evt_drop_d = evt_drop_q;
    evt_id_d   = evt_id_q;
    ack_err_d  = ack_vld & ~ackHit;

    if (tmoHit) begin
      state_d  = ST_HOLD;
      evt_id_d = tmoid;
      if (capRty) begin
        rcnt_d[tmoid] = rcnt_q[tmoid] + 1'b1;
        evt_drop_d    = EVT_RETRY;
      end else begin
        rcnt_d[tmoid]    = '0;
        reqwait_d[tmoid] = 1'b0;
        evt_drop_d       = EVT_DROP;
      end
    end else if ((state_q == ST_HOLD) && evt_rdy) begin
      state_d = ST_IDLE;
    end

    if (ackHit) begin
      reqwait_d[ack_id] = 1'b0;
      rcnt_d[ack_id]    = '0;
    end

    if (req_vld && reqIn) begin
      reqwait_d[req_id] = 1'b1;
      rcnt_d[req_id]    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reqwait_q  <= '0;
      for (int i = 0; i < NCH; i++)
        rcnt_q[i] <= '0;
      state_q    <= ST_IDLE;
      evt_drop_q <= 1'b0;
      evt_id_q   <= '0;
      ack_err_q  <= 1'b0;
    end else begin
      reqwait_q  <= reqwait_d;
      rcnt_q     <= rcnt_d;
      state_q    <= state_d;
      evt_drop_q <= evt_drop_d;
      evt_id_q   <= evt_id_d;
      ack_err_q  <= ack_err_d;
    end
  end

  assign reqwait  = reqwait_q;
  assign evt_vld  = (state_q == ST_HOLD);
  assign evt_drop = evt_drop_q;
  assign evt_id   = evt_id_q;
  assign ack_err  = ack_err_q;

`ifdef IPSMACGE_TXWAITSCH_STAT_EN
  ipsmacge_txwaitsch_stat u_stat (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (stat_clr),
    .inc_rty_i   (capRty),
    .inc_drop_i  (capDrop),
    .stat_rty_o  (stat_rty),
    .stat_drop_o (stat_drop)
  );
`endif

endmodule

// File: tb/tb_ipsmacge_txwaitsch.sv
// Self-checking bench for ipsmacge_txwaitsch: directed scenarios followed by
// randomized traffic against a behavioural reference model.
module tb_ipsmacge_txwaitsch;

  localparam int NCH    = 256;
  localparam int IDBIT  = 8;
  localparam int MAXRTY = 3;

  logic             clk = 1'b0;
  logic             rst, enable, req_vld, ack_vld, tmo, evt_rdy, stat_clr;
  logic [IDBIT-1:0] req_id, ack_id, tmoid;
  logic [NCH-1:0]   reqwait;
  logic             upact, evt_vld, evt_drop, ack_err;
  logic [IDBIT-1:0] evt_id;
  logic [15:0]      stat_rty, stat_drop;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [NCH-1:0]   mWait;
  int               mRcnt [NCH];
  bit               mHold, mDrop, mAckErr;
  logic [IDBIT-1:0] mId;
  int               mStatRty, mStatDrop;

  ipsmacge_txwaitsch dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .req_vld  (req_vld),
    .req_id   (req_id),
    .ack_vld  (ack_vld),
    .ack_id   (ack_id),
    .reqwait  (reqwait),
    .upact    (upact),
    .tmo      (tmo),
    .tmoid    (tmoid),
    .evt_vld  (evt_vld),
    .evt_drop (evt_drop),
    .evt_id   (evt_id),
    .evt_rdy  (evt_rdy),
    .ack_err  (ack_err)
`ifdef IPSMACGE_TXWAITSCH_STAT_EN
    ,
    .stat_clr  (stat_clr),
    .stat_rty  (stat_rty),
    .stat_drop (stat_drop)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic modelStep();
    bit upactNow, ackHit, cap;
    upactNow = !rst && enable && !mHold;
    ackHit   = ack_vld && (int'(ack_id) < NCH) && mWait[ack_id];
    cap      = tmo && upactNow && (int'(tmoid) < NCH) && mWait[tmoid] &&
               !(ack_vld && ack_id == tmoid);
    if (rst) begin
      mWait = '0;
      for (int i = 0; i < NCH; i++) mRcnt[i] = 0;
      mHold = 0; mDrop = 0; mId = '0; mAckErr = 0;
      mStatRty = 0; mStatDrop = 0;
    end else begin
      mAckErr = ack_vld && !ackHit;
      if (cap) begin
        mHold = 1;
        mId   = tmoid;
        if (mRcnt[tmoid] < MAXRTY) begin
          mRcnt[tmoid]++;
          mDrop = 0;
          if (mStatRty < 65535) mStatRty++;
        end else begin
          mRcnt[tmoid] = 0;
          mWait[tmoid] = 1'b0;
          mDrop = 1;
          if (mStatDrop < 65535) mStatDrop++;
        end
      end else if (mHold && evt_rdy) begin
        mHold = 0;
      end
      if (ackHit) begin
        mWait[ack_id] = 1'b0;
        mRcnt[ack_id] = 0;
      end
      if (req_vld && int'(req_id) < NCH) begin
        mWait[req_id] = 1'b1;
        mRcnt[req_id] = 0;
      end
`ifdef IPSMACGE_TXWAITSCH_STAT_EN
      if (stat_clr) begin
        mStatRty  = 0;
        mStatDrop = 0;
      end
`endif
    end
  endtask

  task automatic checkOutput();
    chk("reqwait",  reqwait, mWait);
    chk("upact",    NCH'(upact), NCH'(!rst && enable && !mHold));
    chk("evt_vld",  NCH'(evt_vld), NCH'(mHold));
    chk("evt_drop", NCH'(evt_drop), NCH'(mDrop));
    chk("evt_id",   NCH'(evt_id), NCH'(mId));
    chk("ack_err",  NCH'(ack_err), NCH'(mAckErr));
`ifdef IPSMACGE_TXWAITSCH_STAT_EN
    chk("stat_rty",  NCH'(stat_rty), NCH'(mStatRty));
    chk("stat_drop", NCH'(stat_drop), NCH'(mStatDrop));
`endif
  endtask

  task automatic applyStimulus(input bit rq = 0, input logic [IDBIT-1:0] rqid = '0,
                               input bit ak = 0, input logic [IDBIT-1:0] akid = '0,
                               input bit tm = 0, input logic [IDBIT-1:0] tmid = '0,
                               input bit rdy = 0, input bit en = 1, input bit rs = 0,
                               input bit clr = 0);
    req_vld = rq;  req_id = rqid;
    ack_vld = ak;  ack_id = akid;
    tmo     = tm;  tmoid  = tmid;
    evt_rdy = rdy; enable = en; rst = rs; stat_clr = clr;
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    applyStimulus(.rs(1));
    applyStimulus(.rs(1), .en(1));
    chk("reset_upact", NCH'(upact), NCH'(0));

    // Request / ack / stray ack on channel 5
    applyStimulus(.rq(1), .rqid(8'd5));
    chk("req5", NCH'(reqwait[5]), NCH'(1));
    applyStimulus(.ak(1), .akid(8'd5));
    chk("ack5", NCH'(reqwait[5]), NCH'(0));
    applyStimulus(.ak(1), .akid(8'd5));
    chk("ack_err_pulse", NCH'(ack_err), NCH'(1));
    applyStimulus();
    chk("ack_err_clear", NCH'(ack_err), NCH'(0));

    // Retries then drop on channel 7
    applyStimulus(.rq(1), .rqid(8'd7));
    for (int k = 0; k < 4; k++) begin
      applyStimulus(.tm(1), .tmid(8'd7));
      chk("cap_vld", NCH'(evt_vld), NCH'(1));
      chk("cap_drop", NCH'(evt_drop), NCH'(k == 3));
      chk("cap_upact", NCH'(upact), NCH'(0));
      applyStimulus();
      applyStimulus(.rdy(1));
      chk("rdy_vld", NCH'(evt_vld), NCH'(0));
    end
    chk("drop7_wait", NCH'(reqwait[7]), NCH'(0));

    // Timeout and ack race on channel 9
    applyStimulus(.rq(1), .rqid(8'd9));
    applyStimulus(.ak(1), .akid(8'd9), .tm(1), .tmid(8'd9));
    chk("race9_vld", NCH'(evt_vld), NCH'(0));
    chk("race9_upact", NCH'(upact), NCH'(1));

    // Req and ack together on 3, then timeout on an idle channel
    applyStimulus(.rq(1), .rqid(8'd3), .ak(1), .akid(8'd3));
    chk("reqack3", NCH'(reqwait[3]), NCH'(1));
    applyStimulus(.tm(1), .tmid(8'd200));
    chk("tmo200_vld", NCH'(evt_vld), NCH'(0));
    applyStimulus(.ak(1), .akid(8'd3));

    // Long hold on channel 11, then reset mid-hold
    applyStimulus(.rq(1), .rqid(8'd11));
    applyStimulus(.tm(1), .tmid(8'd11));
    for (int k = 0; k < 10; k++) begin
      applyStimulus(.tm(1), .tmid(8'd11), .rq(k == 4), .rqid(8'd11));
      chk("hold_id", NCH'(evt_id), NCH'(11));
      chk("hold_upact", NCH'(upact), NCH'(0));
    end
    applyStimulus(.rs(1));
    chk("rst_vld", NCH'(evt_vld), NCH'(0));
    chk("rst_wait", reqwait, '0);
    applyStimulus();

`ifdef IPSMACGE_TXWAITSCH_STAT_EN
    applyStimulus(.clr(1));
    applyStimulus(.rq(1), .rqid(8'd12));
    for (int k = 0; k < 4; k++) begin
      applyStimulus(.tm(1), .tmid(8'd12));
      applyStimulus(.rdy(1));
    end
    chk("stat_rty3", NCH'(stat_rty), NCH'(3));
    chk("stat_drop1", NCH'(stat_drop), NCH'(1));
    applyStimulus(.rq(1), .rqid(8'd12));
    applyStimulus(.tm(1), .tmid(8'd12), .clr(1));
    chk("stat_clr_rty", NCH'(stat_rty), NCH'(0));
    applyStimulus(.rdy(1));
`endif

    // Randomized traffic over a small id window
    for (int n = 0; n < 800; n++) begin
      applyStimulus(.rq($urandom_range(0, 2) == 0), .rqid(8'($urandom_range(0, 15))),
                    .ak($urandom_range(0, 3) == 0), .akid(8'($urandom_range(0, 15))),
                    .tm($urandom_range(0, 1) == 0), .tmid(8'($urandom_range(0, 15))),
                    .rdy($urandom_range(0, 2) == 0), .en($urandom_range(0, 9) != 0),
                    .rs($urandom_range(0, 99) == 0), .clr($urandom_range(0, 49) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
